radix2_serial_div: RTL

RADIX2_SERIAL_DIV -- requirements
Module: radix2_serial_div

---
 rtl/arith_pkg.sv | 18 +
 rtl/restoring_div_step.sv | 17 +
 rtl/radix2_serial_div.sv | 81 ++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encodings, width constants and helpers for the serial multiplier/divider
package arith_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } arith_state_t;
  // Multiplier yields MUL_OUT_FACTOR*WIDTH bits; divider yields WIDTH-bit quotient and remainder
  localparam int MUL_OUT_FACTOR = 2;
  localparam int DIV_OUT_FACTOR = 1;
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one radix-2 restoring step (shift in dividend bit, trial-subtract, select)
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  assign shifted  = {rem, bit_in};
  assign diff     = shifted - {2'b00, dvs};
  assign q_bit    = shifted >= {2'b00, dvs};
  assign rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
endmodule

// File: rtl/radix2_serial_div.sv
// radix2_serial_div: signed WIDTH-bit serial restoring divider, one quotient bit per cycle
module radix2_serial_div
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             finished
);
  localparam int CW = ceil_log2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  arith_state_t state, next_state;
  logic [WIDTH-1:0] x_r, y_r, mag_y, dq;
  logic [WIDTH:0]   rem, rem_next;
  logic [CW-1:0]    cnt;
  logic             sign_q, sign_r, dbz, q_bit;
  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (dq[WIDTH-1]),
    .dvs      (mag_y),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
  assign finished = state == IDLE;
  always_comb begin
    next_state = state;
    next_state = state == IDLE ? (start ? PREP : IDLE) :
                 state == PREP ? RUN :
                 state == RUN  ? (cnt == LAST ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;
  // dq holds the dividend magnitude and fills with quotient bits as it shifts out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_r         <= '0;
      y_r         <= '0;
      mag_y       <= '0;
      dq          <= '0;
      rem         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        x_r <= in_x;
        y_r <= in_y;
      end
      if (state == PREP) begin
        dq     <= x_r[WIDTH-1] ? -x_r : x_r;
        mag_y  <= y_r[WIDTH-1] ? -y_r : y_r;
        sign_q <= x_r[WIDTH-1] ^ y_r[WIDTH-1];
        sign_r <= x_r[WIDTH-1];
        dbz    <= y_r == '0;
        rem    <= '0;
        cnt    <= '0;
      end
      if (state == RUN) begin
        rem <= rem_next;
        dq  <= {dq[WIDTH-2:0], q_bit};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        quotient    <= dbz ? '1 : (sign_q ? -dq : dq);
        remainder   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        div_by_zero <= dbz;
      end
    end
endmodule
